sat_scale_ctrl: RTL

Per-frame saturation monitor and scaling scheduler for the FFT butterfly saturation stage. It takes the per-lane overflow flags of the 16-path saturation datapath, totals them over each FFT frame, and after every frame picks the right-shift (block scaling) that the upstream butterfly applies to the next frame. It sits beside the saturation stage in each FFT pipeline stage. Software can override it through a configuration load port.

---
 rtl/sat_scale_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sat_scale_ctrl.sv
// Per-frame saturation monitor and block-scaling scheduler for the FFT saturation stage.
// Optional macro SAT_SCALE_HYST_EN enables the down-step after DOWN_FRAMES clean frames.
module sat_scale_ctrl #(
  parameter int NUM_PARALLEL_PATHS = 16,
  parameter int FRAME_BEATS        = 32,
  parameter int CNT_W              = 10,
  parameter int MAX_SHIFT          = 3,
  parameter int UP_THRESH          = 4,
  parameter int DOWN_FRAMES        = 4,
  localparam int SHIFT_W           = $clog2(MAX_SHIFT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic                          i_sop,
  input  logic [NUM_PARALLEL_PATHS-1:0] i_sat_real,
  input  logic [NUM_PARALLEL_PATHS-1:0] i_sat_imag,
  input  logic                          i_cfg_load,
  input  logic [SHIFT_W-1:0]            i_cfg_shift,
  output logic [SHIFT_W-1:0]            o_shift,
  output logic                          o_shift_upd,
  output logic                          o_frame_done,
  output logic [CNT_W-1:0]              o_frame_sat_cnt,
  output logic                          o_frame_err
);

  localparam int FLAG_W = 2 * NUM_PARALLEL_PATHS;
  localparam int PC_W   = $clog2(FLAG_W + 1);
  localparam int BC_W   = $clog2(FRAME_BEATS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic logic [PC_W-1:0] popcount(input logic [FLAG_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < FLAG_W; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PC_W-1:0]  b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_t              state_r;
  logic [CNT_W-1:0]    acc_r;
  logic [BC_W-1:0]     beat_cnt_r;

  logic [PC_W-1:0]     pc_s;
  logic [CNT_W-1:0]    sum_s;
  logic                last_s;
  logic [SHIFT_W-1:0]  next_shift_s;
  logic                upd_s;
  logic [SHIFT_W-1:0]  cfg_shift_s;

`ifdef SAT_SCALE_HYST_EN
  localparam int Q_W = $clog2(DOWN_FRAMES + 1);
  logic [Q_W-1:0]      quiet_r;
  logic [Q_W-1:0]      next_quiet_s;
  logic [Q_W-1:0]      quiet_inc_s;
`endif

  // Beat popcount, saturating running total and the end-of-frame shift decision.
  always_comb begin
    pc_s         = popcount({i_sat_imag, i_sat_real});
    sum_s        = sat_add(acc_r, pc_s);
    last_s       = (beat_cnt_r == BC_W'(FRAME_BEATS - 1));
    next_shift_s = o_shift;
    upd_s        = 1'b0;
    if (i_cfg_shift > SHIFT_W'(MAX_SHIFT)) begin
      cfg_shift_s = SHIFT_W'(MAX_SHIFT);
    end else begin
      cfg_shift_s = i_cfg_shift;
    end
`ifdef SAT_SCALE_HYST_EN
    next_quiet_s = quiet_r;
    if (quiet_r == Q_W'(DOWN_FRAMES)) begin
      quiet_inc_s = quiet_r;
    end else begin
      quiet_inc_s = quiet_r + Q_W'(1);
    end
`endif
    if (sum_s > CNT_W'(UP_THRESH)) begin
      if (o_shift < SHIFT_W'(MAX_SHIFT)) begin
        next_shift_s = o_shift + SHIFT_W'(1);
        upd_s        = 1'b1;
      end else begin
        next_shift_s = o_shift;
      end
`ifdef SAT_SCALE_HYST_EN
      next_quiet_s = '0;
`endif
    end else if (sum_s == '0) begin
`ifdef SAT_SCALE_HYST_EN
      if ((quiet_inc_s == Q_W'(DOWN_FRAMES)) && (o_shift != '0)) begin
        next_shift_s = o_shift - SHIFT_W'(1);
        upd_s        = 1'b1;
        next_quiet_s = '0;
      end else begin
        next_quiet_s = quiet_inc_s;
      end
`else
      next_shift_s = o_shift;
`endif
    end else begin
`ifdef SAT_SCALE_HYST_EN
      next_quiet_s = '0;
`else
      next_shift_s = o_shift;
`endif
    end
  end

  // Frame FSM, accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    o_shift_upd  <= 1'b0;
    o_frame_done <= 1'b0;
    o_frame_err  <= 1'b0;
    if (rst) begin
      state_r         <= IDLE;
      acc_r           <= '0;
      beat_cnt_r      <= '0;
      o_shift         <= '0;
      o_frame_sat_cnt <= '0;
`ifdef SAT_SCALE_HYST_EN
      quiet_r         <= '0;
`endif
    end else if (i_cfg_load) begin
      state_r    <= IDLE;
      acc_r      <= '0;
      beat_cnt_r <= '0;
      o_shift    <= cfg_shift_s;
`ifdef SAT_SCALE_HYST_EN
      quiet_r    <= '0;
`endif
    end else if (i_valid) begin
      case (state_r)
        IDLE: begin
          if (i_sop) begin
            acc_r      <= CNT_W'(pc_s);
            beat_cnt_r <= BC_W'(1);
            state_r    <= ACCUM;
          end else begin
            state_r    <= IDLE;
          end
        end
        ACCUM: begin
          if (i_sop) begin
            // A stray start aborts the frame and restarts counting from this beat.
            o_frame_err <= 1'b1;
            acc_r       <= CNT_W'(pc_s);
            beat_cnt_r  <= BC_W'(1);
          end else if (last_s) begin
            o_frame_done    <= 1'b1;
            o_frame_sat_cnt <= sum_s;
            o_shift         <= next_shift_s;
            o_shift_upd     <= upd_s;
            acc_r           <= '0;
            beat_cnt_r      <= '0;
            state_r         <= IDLE;
`ifdef SAT_SCALE_HYST_EN
            quiet_r         <= next_quiet_s;
`endif
          end else begin
            acc_r      <= sum_s;
            beat_cnt_r <= beat_cnt_r + BC_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          acc_r      <= '0;
          beat_cnt_r <= '0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule
